// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: access-size codes and lane count.
package mem_pkg;
  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_BYTE = 2'b10;
  localparam int LANES = 4;
endpackage

// File: rtl/mem_wb_stage_align.sv
// mem_lane_align: store byte-enable/data steering and load lane extract/extend.
// Low address bits below the access size are ignored (force-aligned).
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]       st_dt,
  input  logic [1:0]       st_addr,
  input  logic [31:0]      st_data,
  output logic [LANES-1:0] st_be,
  output logic [31:0]      st_wdata,
  input  logic [1:0]       ld_dt,
  input  logic [1:0]       ld_addr,
  input  logic             ld_uns,
  input  logic [31:0]      ld_word,
  output logic [31:0]      ld_data
);
  logic [31:0] sh;
  logic [15:0] h;
  logic [7:0]  b;

  always_comb begin
    st_be    = '1;
    st_wdata = st_data;
    case (st_dt)
      DT_HALF: begin
        st_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      DT_BYTE: begin
        st_be    = 4'b0001 << st_addr;
        st_wdata = {4{st_data[7:0]}};
      end
      default: ;
    endcase
  end

  assign sh = ld_word >> {ld_addr, 3'b000};
  assign h  = ld_addr[1] ? ld_word[31:16] : ld_word[15:0];
  assign b  = sh[7:0];

  always_comb begin
    ld_data = ld_word;
    case (ld_dt)
      DT_HALF: ld_data = ld_uns ? {16'h0, h} : {{16{h[15]}}, h};
      DT_BYTE: ld_data = ld_uns ? {24'h0, b} : {{24{b[7]}}, b};
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with sync-read data RAM and MEM/WB register.
// Optional misalignment trap: define MEM_MISALIGN_TRAP_EN.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Ld,
  input  logic        Flush,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemtoReg,
  input  logic        MEM_MemWrite,
  input  logic        MEM_MemRead,
  input  logic        MEM_Branch,
  input  logic        MEM_Zero,
  input  logic        MEM_Jump,
  input  logic        MEM_LoadUnsigned,
  input  logic [1:0]  MEM_Datatype,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_Data2,
  input  logic [4:0]  MEM_RegDstData,
  output logic        PCSrc,
  output logic        WB_RegWrite,
  output logic        WB_MemtoReg,
  output logic [31:0] WB_ReadData,
  output logic [31:0] WB_ALUResult,
  output logic [4:0]  WB_RegDstData,
  output logic        MisalignErr
);
  logic [31:0]      ram [DEPTH_WORDS];
  logic [31:0]      rword_q, wdata, ext;
  logic [LANES-1:0] be;
  logic [AW-1:0]    idx;
  logic [1:0]       ld_dt_q, ld_addr_q;
  logic             ld_uns_q, rd_vld_q, mis, st_en;

  assign PCSrc = (MEM_Branch & MEM_Zero) | MEM_Jump;
  assign idx   = MEM_ALUResult[AW+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    case (MEM_Datatype)
      DT_HALF: mis = MEM_ALUResult[0];
      DT_BYTE: mis = 1'b0;
      default: mis = |MEM_ALUResult[1:0];
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      MisalignErr <= 1'b0;
    else if (Ld && !Flush && mis && (MEM_MemRead || MEM_MemWrite))
      MisalignErr <= 1'b1;
  end
`else
  assign mis         = 1'b0;
  assign MisalignErr = 1'b0;
`endif

  assign st_en = MEM_MemWrite & Ld & ~Flush & ~mis;

  mem_lane_align u_align (
    .st_dt   (MEM_Datatype),
    .st_addr (MEM_ALUResult[1:0]),
    .st_data (MEM_Data2),
    .st_be   (be),
    .st_wdata(wdata),
    .ld_dt   (ld_dt_q),
    .ld_addr (ld_addr_q),
    .ld_uns  (ld_uns_q),
    .ld_word (rword_q),
    .ld_data (ext)
  );

  // Read and write in one process so a same-edge read sees the pre-store word.
  always_ff @(posedge Clk) begin
    if (st_en)
      for (int i = 0; i < LANES; i++)
        if (be[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
    if (Ld && MEM_MemRead) rword_q <= ram[idx];
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      WB_RegWrite   <= 1'b0;
      WB_MemtoReg   <= 1'b0;
      WB_ALUResult  <= '0;
      WB_RegDstData <= '0;
      rd_vld_q      <= 1'b0;
      ld_dt_q       <= DT_WORD;
      ld_addr_q     <= '0;
      ld_uns_q      <= 1'b0;
    end else if (Ld) begin
      if (Flush) begin
        WB_RegWrite   <= 1'b0;
        WB_MemtoReg   <= 1'b0;
        WB_ALUResult  <= '0;
        WB_RegDstData <= '0;
        rd_vld_q      <= 1'b0;
      end else begin
        WB_RegWrite   <= MEM_RegWrite & ~(mis & MEM_MemRead);
        WB_MemtoReg   <= MEM_MemtoReg;
        WB_ALUResult  <= MEM_ALUResult;
        WB_RegDstData <= MEM_RegDstData;
        rd_vld_q      <= MEM_MemRead & ~mis;
      end
      ld_dt_q   <= MEM_Datatype;
      ld_addr_q <= MEM_ALUResult[1:0];
      ld_uns_q  <= MEM_LoadUnsigned;
    end
  end

  // Gate keeps the unreset RAM output register from leaking after reset/flush.
  assign WB_ReadData = rd_vld_q ? ext : 32'h0;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed scoreboard bench for mem_wb_stage.
module tb_mem_wb_stage;
  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        rw;
    logic [31:0] alu;
  } exp_t;

  logic        Clk = 0, Rst = 1, Ld = 0, Flush = 0;
  logic        MEM_RegWrite = 0, MEM_MemtoReg = 0, MEM_MemWrite = 0, MEM_MemRead = 0;
  logic        MEM_Branch = 0, MEM_Zero = 0, MEM_Jump = 0, MEM_LoadUnsigned = 0;
  logic [1:0]  MEM_Datatype = 0;
  logic [31:0] MEM_ALUResult = 0, MEM_Data2 = 0;
  logic [4:0]  MEM_RegDstData = 5'd9;
  logic        PCSrc, WB_RegWrite, WB_MemtoReg, MisalignErr;
  logic [31:0] WB_ReadData, WB_ALUResult;
  logic [4:0]  WB_RegDstData;

  int tests = 0, fails = 0;
  exp_t sb[$];

  mem_wb_stage dut (
    .Clk(Clk), .Rst(Rst), .Ld(Ld), .Flush(Flush),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
    .MEM_MemWrite(MEM_MemWrite), .MEM_MemRead(MEM_MemRead),
    .MEM_Branch(MEM_Branch), .MEM_Zero(MEM_Zero), .MEM_Jump(MEM_Jump),
    .MEM_LoadUnsigned(MEM_LoadUnsigned), .MEM_Datatype(MEM_Datatype),
    .MEM_ALUResult(MEM_ALUResult), .MEM_Data2(MEM_Data2),
    .MEM_RegDstData(MEM_RegDstData), .PCSrc(PCSrc),
    .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
    .WB_ReadData(WB_ReadData), .WB_ALUResult(WB_ALUResult),
    .WB_RegDstData(WB_RegDstData), .MisalignErr(MisalignErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk1(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Drive one MEM-stage beat, push its expected WB result, clock, then pop/compare.
  task automatic op(input string tag, input logic ld, fl, we, re, input logic [1:0] dt,
                    input logic uns, input logic [31:0] addr, data,
                    input logic [31:0] erd, input logic erw, input logic [31:0] ealu);
    exp_t e;
    Ld = ld; Flush = fl; MEM_MemWrite = we; MEM_MemRead = re;
    MEM_RegWrite = re; MEM_MemtoReg = re; MEM_Datatype = dt;
    MEM_LoadUnsigned = uns; MEM_ALUResult = addr; MEM_Data2 = data;
    sb.push_back('{tag, erd, erw, ealu});
    @(posedge Clk); #1;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk1({e.tag, ".rd"}, WB_ReadData, e.rd);
      chk1({e.tag, ".rw"}, {31'h0, WB_RegWrite}, {31'h0, e.rw});
      chk1({e.tag, ".alu"}, WB_ALUResult, e.alu);
    end
    Ld = 0; Flush = 0; MEM_MemWrite = 0; MEM_MemRead = 0;
  endtask

  initial begin
    #12;
    chk1("rst.rd", WB_ReadData, 32'h0);
    chk1("rst.rw", {31'h0, WB_RegWrite}, 32'h0);
    chk1("rst.alu", WB_ALUResult, 32'h0);
    chk1("rst.err", {31'h0, MisalignErr}, 32'h0);
    @(negedge Clk); Rst = 0;

    op("st_w10",  1,0,1,0, 2'b00,0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 32'h10);
    op("ld_w10",  1,0,0,1, 2'b00,0, 32'h10, 32'h0, 32'hDEADBEEF, 1, 32'h10);
    op("st_b13",  1,0,1,0, 2'b10,0, 32'h13, 32'h00000080, 32'h0, 0, 32'h13);
    op("ld_bs13", 1,0,0,1, 2'b10,0, 32'h13, 32'h0, 32'hFFFFFF80, 1, 32'h13);
    op("ld_bu13", 1,0,0,1, 2'b10,1, 32'h13, 32'h0, 32'h00000080, 1, 32'h13);
    op("ld_w10b", 1,0,0,1, 2'b00,0, 32'h10, 32'h0, 32'h80ADBEEF, 1, 32'h10);
    op("ld_hs12", 1,0,0,1, 2'b01,0, 32'h12, 32'h0, 32'hFFFF80AD, 1, 32'h12);
    op("ld_bu11", 1,0,0,1, 2'b10,1, 32'h11, 32'h0, 32'h000000BE, 1, 32'h11);
    op("st_w20",  1,0,1,0, 2'b00,0, 32'h20, 32'h55667788, 32'h0, 0, 32'h20);
    op("st_h22",  1,0,1,0, 2'b01,0, 32'h22, 32'hABCD1234, 32'h0, 0, 32'h22);
    op("ld_h22",  1,0,0,1, 2'b01,0, 32'h22, 32'h0, 32'h00001234, 1, 32'h22);
    op("ld_w20",  1,0,0,1, 2'b00,0, 32'h20, 32'h0, 32'h12347788, 1, 32'h20);
    op("rmw_w20", 1,0,1,1, 2'b00,0, 32'h20, 32'h11111111, 32'h12347788, 1, 32'h20);
    op("ld_w20b", 1,0,0,1, 2'b00,0, 32'h20, 32'h0, 32'h11111111, 1, 32'h20);
    op("wrap",    1,0,0,1, 2'b00,0, 32'h1010, 32'h0, 32'h80ADBEEF, 1, 32'h1010);

    op("st_w30",  1,0,1,0, 2'b00,0, 32'h30, 32'h0BADF00D, 32'h0, 0, 32'h30);
    op("ld_w10c", 1,0,0,1, 2'b00,0, 32'h10, 32'h0, 32'h80ADBEEF, 1, 32'h10);
    for (int i = 0; i < 3; i++)
      op("stall", 0,0,1,0, 2'b00,0, 32'h30, 32'hFFFFFFFF, 32'h80ADBEEF, 1, 32'h10);
    op("ld_w30",  1,0,0,1, 2'b00,0, 32'h30, 32'h0, 32'h0BADF00D, 1, 32'h30);

    op("flush",   1,1,1,1, 2'b00,0, 32'h10, 32'h0, 32'h0, 0, 32'h0);
    op("ld_w10d", 1,0,0,1, 2'b00,0, 32'h10, 32'h0, 32'h80ADBEEF, 1, 32'h10);

    MEM_Branch = 1; MEM_Zero = 1; #1;
    chk1("pcsrc_bz", {31'h0, PCSrc}, 32'h1);
    MEM_Zero = 0; #1;
    chk1("pcsrc_b", {31'h0, PCSrc}, 32'h0);
    MEM_Branch = 0; MEM_Jump = 1; #1;
    chk1("pcsrc_j", {31'h0, PCSrc}, 32'h1);
    MEM_Jump = 0;

    op("st_w40",  1,0,1,0, 2'b00,0, 32'h40, 32'h00000000, 32'h0, 0, 32'h40);
    op("st_w41",  1,0,1,0, 2'b00,0, 32'h41, 32'hCAFEF00D, 32'h0, 0, 32'h41);
`ifdef MEM_MISALIGN_TRAP_EN
    chk1("mis.err", {31'h0, MisalignErr}, 32'h1);
    op("ld_w40m", 1,0,0,1, 2'b00,0, 32'h40, 32'h0, 32'h00000000, 1, 32'h40);
    op("ld_w41m", 1,0,0,1, 2'b00,0, 32'h41, 32'h0, 32'h00000000, 0, 32'h41);
    op("ld_h42",  1,0,0,1, 2'b01,0, 32'h42, 32'h0, 32'h00000000, 1, 32'h42);
    chk1("mis.sticky", {31'h0, MisalignErr}, 32'h1);
`else
    chk1("mis.err0", {31'h0, MisalignErr}, 32'h0);
    op("ld_w40",  1,0,0,1, 2'b00,0, 32'h40, 32'h0, 32'hCAFEF00D, 1, 32'h40);
`endif

    #2 Rst = 1; #1;
    chk1("rst2.rd", WB_ReadData, 32'h0);
    chk1("rst2.rw", {31'h0, WB_RegWrite}, 32'h0);
    chk1("rst2.err", {31'h0, MisalignErr}, 32'h0);
    @(negedge Clk); Rst = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
